// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the two-requester memory port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    typedef enum logic {
        REQ_IF = 1'b0,
        REQ_LS = 1'b1
    } req_id_t;

    // Supported memory read latencies are 1..4 cycles.
    function automatic bit rd_lat_valid(input int unsigned lat);
        return (lat >= 1) && (lat <= 4);
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin pick between IF and LS; the pointer remembers the last
// granted requester and moves on every accepted grant.
module rr_arbiter2
    import mem_arb_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    input  logic    req_if,
    input  logic    req_ls,
    input  logic    grant,
    output req_id_t winner,
    output logic    any_req
);

    req_id_t last_q;

    // Resetting to "IF granted last" makes LS win the first tie.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_q <= REQ_IF;
        end else if (grant && any_req) begin
            last_q <= winner;
        end
    end

    always_comb begin
        any_req = req_if | req_ls;
        winner  = REQ_IF;
        if (req_if && req_ls) begin
            if (last_q == REQ_IF) begin
                winner = REQ_LS;
            end else begin
                winner = REQ_IF;
            end
        end else if (req_ls) begin
            winner = REQ_LS;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one little-endian 32-bit memory port between instruction fetch (read-only)
// and load/store, with round-robin arbitration, bounds checking and configurable read latency.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned MEM_BYTES = 25,
    parameter int unsigned RD_LAT    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_err,
    input  logic              ls_req,
    input  logic              ls_we,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [DATA_W-1:0] ls_wdata,
    output logic              ls_gnt,
    output logic              ls_rvalid,
    output logic [DATA_W-1:0] ls_rdata,
    output logic              ls_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    localparam int unsigned     LAT       = rd_lat_valid(RD_LAT) ? RD_LAT : 1;
    localparam int unsigned     CW        = $clog2(LAT + 1);
    localparam logic [ADDR_W:0] LAST_BASE = (ADDR_W + 1)'(MEM_BYTES - 4);

    state_t            state_q, state_d;
    req_id_t           owner_q, winner;
    logic              any_req, start, we_q, err_q, rd_op, last_cyc;
    logic [CW-1:0]     cnt_q;
    logic [DATA_W-1:0] resp_q;
    logic [ADDR_W-1:0] win_addr;

    rr_arbiter2 u_rr (
        .clk    (clk),
        .rst    (rst),
        .req_if (if_req),
        .req_ls (ls_req),
        .grant  (state_q == IDLE),
        .winner (winner),
        .any_req(any_req)
    );

    assign start    = (state_q == IDLE) && any_req;
    assign win_addr = (winner == REQ_LS) ? ls_addr : if_addr;
    assign rd_op    = !we_q && !err_q;
    // ACCESS cycle 0 is the grant/address phase; the memory operation follows.
    assign last_cyc = (cnt_q == (rd_op ? CW'(LAT) : CW'(1)));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner_q   <= REQ_IF;
            we_q      <= 1'b0;
            err_q     <= 1'b0;
            cnt_q     <= '0;
            resp_q    <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else if (start) begin
            owner_q   <= winner;
            we_q      <= (winner == REQ_LS) && ls_we;
            // Widened compare so addresses near the top of the space never wrap to legal.
            err_q     <= ({1'b0, win_addr} > LAST_BASE);
            mem_addr  <= win_addr;
            mem_wdata <= (winner == REQ_LS) ? ls_wdata : '0;
            cnt_q     <= '0;
            resp_q    <= '0;
        end else if (state_q == ACCESS) begin
            cnt_q <= cnt_q + 1'b1;
            if (last_cyc && rd_op) begin
                resp_q <= mem_rdata;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (any_req) state_d = ACCESS;
            ACCESS:  if (last_cyc) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state_q != IDLE);
        if_gnt    = 1'b0;
        ls_gnt    = 1'b0;
        if_rvalid = 1'b0;
        ls_rvalid = 1'b0;
        if_rdata  = '0;
        ls_rdata  = '0;
        if_err    = 1'b0;
        ls_err    = 1'b0;
        mem_re    = 1'b0;
        mem_we    = 1'b0;
        case (state_q)
            ACCESS: begin
                if (cnt_q == '0) begin
                    if_gnt = (owner_q == REQ_IF);
                    ls_gnt = (owner_q == REQ_LS);
                end else begin
                    mem_re = rd_op;
                    mem_we = we_q && !err_q;
                end
            end
            RESP: begin
                if (owner_q == REQ_IF) begin
                    if_rvalid = 1'b1;
                    if_rdata  = resp_q;
                    if_err    = err_q;
                end else begin
                    ls_rvalid = 1'b1;
                    ls_rdata  = resp_q;
                    ls_err    = err_q;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: byte-array memory model, per-port scoreboards,
// and a second instance with a 3-cycle read latency.
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    logic        if_req, if_gnt, if_rvalid, if_err;
    logic [31:0] if_addr, if_rdata;
    logic        ls_req, ls_we, ls_gnt, ls_rvalid, ls_err;
    logic [31:0] ls_addr, ls_wdata, ls_rdata;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_we, mem_re, busy;

    logic        d3_if_req, d3_if_gnt, d3_if_rvalid, d3_if_err;
    logic [31:0] d3_if_addr, d3_if_rdata;
    logic        d3_ls_req, d3_ls_we, d3_ls_gnt, d3_ls_rvalid, d3_ls_err;
    logic [31:0] d3_ls_addr, d3_ls_wdata, d3_ls_rdata;
    logic [31:0] d3_mem_addr, d3_mem_wdata, d3_mem_rdata;
    logic        d3_mem_we, d3_mem_re, d3_busy;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_BYTES(25), .RD_LAT(1)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
        .if_rdata(if_rdata), .if_err(if_err),
        .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
        .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata), .ls_err(ls_err),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_BYTES(25), .RD_LAT(3)) dut3 (
        .clk(clk), .rst(rst),
        .if_req(d3_if_req), .if_addr(d3_if_addr), .if_gnt(d3_if_gnt), .if_rvalid(d3_if_rvalid),
        .if_rdata(d3_if_rdata), .if_err(d3_if_err),
        .ls_req(d3_ls_req), .ls_we(d3_ls_we), .ls_addr(d3_ls_addr), .ls_wdata(d3_ls_wdata),
        .ls_gnt(d3_ls_gnt), .ls_rvalid(d3_ls_rvalid), .ls_rdata(d3_ls_rdata), .ls_err(d3_ls_err),
        .mem_addr(d3_mem_addr), .mem_wdata(d3_mem_wdata), .mem_we(d3_mem_we), .mem_re(d3_mem_re),
        .mem_rdata(d3_mem_rdata), .busy(d3_busy)
    );

    function automatic logic [31:0] init_word(input logic [31:0] a);
        logic [31:0] w;
        for (int k = 0; k < 4; k++) w[8*k +: 8] = 8'((a + 32'(k)) * 7 + 3);
        return w;
    endfunction

    logic [7:0] mem [32];
    logic       mem_load;

    always @(posedge clk) begin
        if (mem_load) begin
            for (int i = 0; i < 32; i++) mem[i] <= 8'(i * 7 + 3);
        end else if (mem_we) begin
            for (int k = 0; k < 4; k++) mem[5'(mem_addr + 32'(k))] <= mem_wdata[8*k +: 8];
        end
    end

    always_comb begin
        mem_rdata = '0;
        for (int k = 0; k < 4; k++) mem_rdata[8*k +: 8] = mem[5'(mem_addr + 32'(k))];
    end

    assign d3_mem_rdata = init_word(d3_mem_addr);

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   we_cnt, re_cnt, if_gnt_cnt, ls_rv_cnt, d3_re_cnt, d3_busy_cnt;
    exp_t if_q[$];
    exp_t ls_q[$];
    int   gnt_log[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: sample at the falling edge, account events and score responses.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        cyc++;
        we_cnt      += int'(mem_we);
        re_cnt      += int'(mem_re);
        d3_re_cnt   += int'(d3_mem_re);
        d3_busy_cnt += int'(d3_busy);
        if (if_gnt) begin if_gnt_cnt++; gnt_log.push_back(0); end
        if (ls_gnt) gnt_log.push_back(1);
        if (if_rvalid || ls_rvalid) chk("rvalid_exclusive", 32'(if_rvalid & ls_rvalid), 0);
        if (if_rvalid) begin
            chk("if_rvalid_expected", 32'(if_q.size() != 0), 1);
            if (if_q.size() != 0) begin
                e = if_q.pop_front();
                chk("if_rdata", if_rdata, e.rdata);
                chk("if_err", 32'(if_err), 32'(e.err));
            end
        end
        if (ls_rvalid) begin
            ls_rv_cnt++;
            chk("ls_rvalid_expected", 32'(ls_q.size() != 0), 1);
            if (ls_q.size() != 0) begin
                e = ls_q.pop_front();
                chk("ls_rdata", ls_rdata, e.rdata);
                chk("ls_err", 32'(ls_err), 32'(e.err));
            end
        end
    endtask

    function automatic bit sig(input int s);
        case (s)
            0:       return if_gnt;
            1:       return ls_gnt;
            2:       return if_rvalid;
            3:       return ls_rvalid;
            4:       return d3_if_gnt;
            default: return d3_if_rvalid;
        endcase
    endfunction

    task automatic wait_sig(input int s, input string tag);
        int n = 0;
        do begin tick(); n++; end while (!sig(s) && n < 40);
        chk({tag, "_seen"}, 32'(sig(s)), 1);
    endtask

    task automatic run_ls(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] rdata, input logic err, input string tag);
        exp_t e;
        int   g;
        e.rdata = rdata; e.err = err;
        ls_q.push_back(e);
        ls_req = 1'b1; ls_we = we; ls_addr = addr; ls_wdata = wdata;
        wait_sig(1, {tag, "_gnt"});
        g = cyc;
        ls_req = 1'b0;
        wait_sig(3, {tag, "_rvalid"});
        chk({tag, "_latency"}, 32'(cyc - g), 2);
    endtask

    task automatic run_if(input logic [31:0] addr, input logic [31:0] rdata, input logic err,
                          input string tag);
        exp_t e;
        int   g;
        e.rdata = rdata; e.err = err;
        if_q.push_back(e);
        if_req = 1'b1; if_addr = addr;
        wait_sig(0, {tag, "_gnt"});
        g = cyc;
        if_req = 1'b0;
        wait_sig(2, {tag, "_rvalid"});
        chk({tag, "_latency"}, 32'(cyc - g), 2);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int g, rv0, ig0, if_left, ls_left;
        int exp_order[4];
        exp_t e;
        exp_order = '{1, 0, 1, 0};
        rst = 1'b0; mem_load = 1'b1;
        if_req = 0; if_addr = '0; ls_req = 0; ls_we = 0; ls_addr = '0; ls_wdata = '0;
        d3_if_req = 0; d3_if_addr = '0; d3_ls_req = 0; d3_ls_we = 0; d3_ls_addr = '0; d3_ls_wdata = '0;
        we_cnt = 0; re_cnt = 0; if_gnt_cnt = 0; ls_rv_cnt = 0; d3_re_cnt = 0; d3_busy_cnt = 0;
        repeat (3) tick();
        mem_load = 1'b0;
        chk("rst_busy", 32'({busy, d3_busy}), 0);
        chk("rst_gnt", 32'({if_gnt, ls_gnt}), 0);
        chk("rst_mem_en", 32'({mem_we, mem_re}), 0);
        chk("rst_mem_addr", mem_addr, 0);
        rst = 1'b1;
        tick();

        // Write then read back the same word
        we_cnt = 0;
        run_ls(1'b1, 32'd4, 32'hDEADBEEF, 32'h0, 1'b0, "t1_wr");
        chk("t1_we_cycles", 32'(we_cnt), 1);
        chk("t1_mem_commit", {mem[7], mem[6], mem[5], mem[4]}, 32'hDEADBEEF);
        run_ls(1'b0, 32'd4, 32'h0, 32'hDEADBEEF, 1'b0, "t1_rd");

        // Both requesters held from reset: alternating grants starting with LS
        rst = 1'b0;
        if_req = 1'b1; if_addr = 32'd0;
        ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'd12;
        for (int i = 0; i < 2; i++) begin
            e.err = 1'b0;
            e.rdata = init_word(32'd0);  if_q.push_back(e);
            e.rdata = init_word(32'd12); ls_q.push_back(e);
        end
        tick(); tick();
        gnt_log.delete();
        if_left = 2; ls_left = 2;
        rst = 1'b1;
        for (int n = 0; n < 60 && (if_q.size() + ls_q.size()) > 0; n++) begin
            tick();
            if (if_gnt) begin if_left--; if (if_left == 0) if_req = 1'b0; end
            if (ls_gnt) begin ls_left--; if (ls_left == 0) ls_req = 1'b0; end
        end
        chk("t2_drained", 32'(if_q.size() + ls_q.size()), 0);
        chk("t2_gnt_count", 32'(gnt_log.size()), 4);
        for (int i = 0; i < 4; i++) chk($sformatf("t2_gnt_order_%0d", i), 32'(gnt_log[i]), 32'(exp_order[i]));
        tick();

        // Bounds: last legal address, first illegal, wrap-around, unaligned, OOR write
        re_cnt = 0;
        run_ls(1'b0, 32'd22, 32'h0, 32'h0, 1'b1, "t3_oor22");
        chk("t3_no_mem_re", 32'(re_cnt), 0);
        run_ls(1'b0, 32'd21, 32'h0, init_word(32'd21), 1'b0, "t3_edge21");
        run_if(32'hFFFFFFFE, 32'h0, 1'b1, "t3_if_wrap");
        run_ls(1'b0, 32'd9, 32'h0, init_word(32'd9), 1'b0, "t3_unaligned");
        we_cnt = 0;
        run_ls(1'b1, 32'd23, 32'hCAFEF00D, 32'h0, 1'b1, "t3_oor_wr");
        chk("t3_no_mem_we", 32'(we_cnt), 0);

        // RD_LAT = 3 instance
        d3_re_cnt = 0; d3_busy_cnt = 0;
        d3_if_req = 1'b1; d3_if_addr = 32'd0;
        wait_sig(4, "t4_gnt");
        g = cyc;
        d3_if_req = 1'b0;
        wait_sig(5, "t4_rvalid");
        chk("t4_latency", 32'(cyc - g), 4);
        chk("t4_rdata", d3_if_rdata, init_word(32'd0));
        chk("t4_err", 32'(d3_if_err), 0);
        tick(); tick();
        chk("t4_re_cycles", 32'(d3_re_cnt), 3);
        chk("t4_busy_cycles", 32'(d3_busy_cnt), 5);

        // Asynchronous reset during a write's memory cycle
        ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'd16; ls_wdata = 32'h12345678;
        wait_sig(1, "t5_gnt");
        ls_req = 1'b0; ls_we = 1'b0;
        tick();
        chk("t5_we_before", 32'(mem_we), 1);
        #2 rst = 1'b0;
        #1;
        chk("t5_we_async", 32'(mem_we), 0);
        chk("t5_busy_async", 32'(busy), 0);
        rv0 = ls_rv_cnt;
        tick(); tick();
        rst = 1'b1;
        tick(); tick();
        chk("t5_no_rvalid", 32'(ls_rv_cnt - rv0), 0);
        chk("t5_no_write", {mem[19], mem[18], mem[17], mem[16]}, init_word(32'd16));
        run_ls(1'b0, 32'd16, 32'h0, init_word(32'd16), 1'b0, "t5_after");

        // IF request withdrawn just before the decision edge
        e.rdata = init_word(32'd20); e.err = 1'b0;
        ls_q.push_back(e);
        ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'd20;
        wait_sig(1, "t6_gnt");
        ls_req = 1'b0;
        if_req = 1'b1; if_addr = 32'd0;
        ig0 = if_gnt_cnt;
        wait_sig(3, "t6_rvalid");
        tick();
        if_req = 1'b0;
        repeat (6) tick();
        chk("t6_no_if_gnt", 32'(if_gnt_cnt - ig0), 0);
        chk("t6_idle", 32'(busy), 0);
        chk("t6_queues_empty", 32'(if_q.size() + ls_q.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
